// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch (I) and load/store (D).
// Handshake: ireq/dreq are levels held until their one-cycle done pulse; mem_req is held until mem_done (one cycle) or timeout.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iadr,
    output logic [31:0] irdata,
    output logic        idone,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] dadr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbyteen,
    output logic [31:0] drdata,
    output logic        ddone,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        mem_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [7:0]    tcount;

    logic i_elig;
    logic d_elig;
    logic starved;
    logic grant_i;
    logic grant_d;
    logic expired;

    // A requester is masked during its own done cycle so a held level is not served twice.
    always_comb begin
        i_elig  = ireq & ~idone;
        d_elig  = dreq & ~ddone;
        starved = i_elig && (starve == STARVE_MAX);
        grant_d = d_elig & ~starved;
        grant_i = i_elig & ~grant_d;
        expired = (tcount == TIMEOUT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve     <= '0;
            tcount     <= '0;
            irdata     <= '0;
            idone      <= 1'b0;
            drdata     <= '0;
            ddone      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            mem_byteen <= '0;
            mem_err    <= 1'b0;
        end else begin
            idone <= 1'b0;
            ddone <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= DBUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= dwe;
                        mem_adr    <= dadr;
                        mem_wdata  <= dwdata;
                        mem_byteen <= dbyteen;
                        tcount     <= '0;
                        if (ireq && (starve != STARVE_MAX)) begin
                            starve <= starve + 1'b1;
                        end
                    end else if (grant_i) begin
                        state      <= IBUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_adr    <= iadr;
                        mem_wdata  <= '0;
                        mem_byteen <= 4'hF;
                        tcount     <= '0;
                        starve     <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    // A real acknowledge on the timeout edge takes precedence over the abort.
                    if (mem_done || expired) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!mem_done) begin
                            mem_err <= 1'b1;
                        end
                        if (state == IBUSY) begin
                            idone  <= 1'b1;
                            irdata <= mem_done ? mem_rdata : ABORT_DATA;
                        end else begin
                            ddone <= 1'b1;
                            if (!mem_done) begin
                                drdata <= ABORT_DATA;
                            end else if (!mem_we) begin
                                drdata <= mem_rdata;
                            end
                        end
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; a transaction-level model predicts grants,
// bus fields, done pulses and read data.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic        clk;
    logic        reset;
    logic        ireq;
    logic [31:0] iadr;
    logic [31:0] irdata;
    logic        idone;
    logic        dreq;
    logic        dwe;
    logic [31:0] dadr;
    logic [31:0] dwdata;
    logic [3:0]  dbyteen;
    logic [31:0] drdata;
    logic        ddone;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;

    mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ireq       (ireq),
        .iadr       (iadr),
        .irdata     (irdata),
        .idone      (idone),
        .dreq       (dreq),
        .dwe        (dwe),
        .dadr       (dadr),
        .dwdata     (dwdata),
        .dbyteen    (dbyteen),
        .drdata     (drdata),
        .ddone      (ddone),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too, half a cycle after they update.
    task automatic tick();
        @(negedge clk);
    endtask

    // Free-running traffic: both requesters issue after random gaps, memory answers after a random delay.
    // The model tracks what each side has pending and how many D grants went by while I waited.
    task automatic run_random(input string tag, input int ncycles, input int max_delay, input int max_gap);
        logic pend_i = 1'b0;
        logic pend_d = 1'b0;
        logic busy = 1'b0;
        logic done_due = 1'b0;
        logic own_d = 1'b0;
        logic exp_req;
        logic want_d;
        logic [31:0] sent_rdata = '0;
        int igap = 1;
        int dgap = 1;
        int dwait = 0;
        int d_while_i = 0;
        int i_issued = 0;
        int d_issued = 0;
        int i_done = 0;
        int d_done = 0;
        ireq = 1'b0;
        dreq = 1'b0;
        mem_done = 1'b0;
        for (int cyc = 0; cyc < ncycles + 300; cyc++) begin
            tick();
            if (done_due && !own_d) begin
                exp_irdata = sent_rdata;
                i_done++;
            end
            if (done_due && own_d) begin
                if (!dwe) exp_drdata = sent_rdata;
                d_done++;
            end
            exp_req = done_due ? 1'b0 : (busy ? 1'b1 : (pend_i | pend_d));
            chk({tag, "_idone"}, idone, done_due && !own_d);
            chk({tag, "_ddone"}, ddone, done_due && own_d);
            chk({tag, "_irdata"}, irdata, exp_irdata);
            chk({tag, "_drdata"}, drdata, exp_drdata);
            chk({tag, "_mem_req"}, mem_req, exp_req);
            chk({tag, "_mem_err"}, mem_err, 1'b0);
            if (exp_req && !busy) begin
                want_d = pend_d && !(pend_i && d_while_i >= STARVE_LIMIT);
                own_d = want_d;
                if (want_d) begin
                    chk({tag, "_d_adr"}, mem_adr, dadr);
                    chk({tag, "_d_we"}, mem_we, dwe);
                    chk({tag, "_d_wdata"}, mem_wdata, dwdata);
                    chk({tag, "_d_byteen"}, mem_byteen, dbyteen);
                    if (pend_i) d_while_i++;
                end else begin
                    chk({tag, "_i_adr"}, mem_adr, iadr);
                    chk({tag, "_i_we"}, mem_we, 1'b0);
                    chk({tag, "_i_wdata"}, mem_wdata, 32'h0);
                    chk({tag, "_i_byteen"}, mem_byteen, 4'hF);
                    d_while_i = 0;
                end
                dwait = int'($urandom_range(max_delay, 0));
            end
            busy = exp_req;
            if (done_due && !own_d) begin
                pend_i = 1'b0;
                igap = int'($urandom_range(max_gap, 1));
            end else if (!pend_i && cyc < ncycles) begin
                igap--;
                if (igap == 0) begin
                    pend_i = 1'b1;
                    iadr = $urandom;
                    i_issued++;
                end
            end
            if (done_due && own_d) begin
                pend_d = 1'b0;
                dgap = int'($urandom_range(max_gap, 1));
            end else if (!pend_d && cyc < ncycles) begin
                dgap--;
                if (dgap == 0) begin
                    pend_d = 1'b1;
                    dwe = 1'($urandom_range(1, 0));
                    dadr = $urandom;
                    dwdata = $urandom;
                    dbyteen = 4'($urandom_range(15, 1));
                    d_issued++;
                end
            end
            ireq = pend_i;
            dreq = pend_d;
            done_due = 1'b0;
            mem_done = 1'b0;
            if (busy) begin
                if (dwait == 0) begin
                    sent_rdata = $urandom;
                    mem_rdata = sent_rdata;
                    mem_done = 1'b1;
                    done_due = 1'b1;
                end else begin
                    dwait--;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                mem_rdata = $urandom;
                mem_done = 1'b1;
            end
            if (cyc >= ncycles && !pend_i && !pend_d && !busy && !done_due) break;
        end
        mem_done = 1'b0;
        ireq = 1'b0;
        dreq = 1'b0;
        tick();
        tick();
        chk({tag, "_i_completed"}, 32'(i_done), 32'(i_issued));
        chk({tag, "_d_completed"}, 32'(d_done), 32'(d_issued));
        chk({tag, "_idle_after"}, mem_req, 1'b0);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        ireq = 1'b0;
        iadr = '0;
        dreq = 1'b0;
        dwe = 1'b0;
        dadr = '0;
        dwdata = '0;
        dbyteen = '0;
        mem_rdata = '0;
        mem_done = 1'b0;

        // Reset values
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_idone", idone, 1'b0);
        chk("rst_ddone", ddone, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_irdata", irdata, 32'h0);
        chk("rst_drdata", drdata, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_byteen", mem_byteen, 4'h0);
        reset = 1'b0;
        tick();

        // Fetch with memory answering three cycles after mem_req
        ireq = 1'b1;
        iadr = 32'h40;
        tick();
        chk("fetch_req", mem_req, 1'b1);
        chk("fetch_adr", mem_adr, 32'h40);
        chk("fetch_byteen", mem_byteen, 4'hF);
        chk("fetch_we", mem_we, 1'b0);
        tick();
        tick();
        chk("fetch_hold", mem_req, 1'b1);
        chk("fetch_no_early_done", idone, 1'b0);
        mem_done = 1'b1;
        mem_rdata = 32'h2002_0005;
        tick();
        chk("fetch_idone", idone, 1'b1);
        chk("fetch_irdata", irdata, 32'h2002_0005);
        chk("fetch_req_drop", mem_req, 1'b0);
        mem_done = 1'b0;
        ireq = 1'b0;
        tick();
        chk("fetch_idone_once", idone, 1'b0);
        exp_irdata = 32'h2002_0005;

        // Load, then a store that must leave drdata alone
        dreq = 1'b1;
        dwe = 1'b0;
        dadr = 32'h60;
        dbyteen = 4'hF;
        tick();
        chk("load_adr", mem_adr, 32'h60);
        mem_done = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("load_ddone", ddone, 1'b1);
        chk("load_drdata", drdata, 32'h1234_5678);
        mem_done = 1'b0;
        dreq = 1'b0;
        tick();
        dreq = 1'b1;
        dwe = 1'b1;
        dadr = 32'h54;
        dwdata = 32'h7;
        dbyteen = 4'hF;
        tick();
        chk("store_we", mem_we, 1'b1);
        chk("store_adr", mem_adr, 32'h54);
        chk("store_wdata", mem_wdata, 32'h7);
        chk("store_byteen", mem_byteen, 4'hF);
        mem_done = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        chk("store_ddone", ddone, 1'b1);
        chk("store_drdata_kept", drdata, 32'h1234_5678);
        mem_done = 1'b0;
        dreq = 1'b0;
        tick();
        chk("store_ddone_once", ddone, 1'b0);
        exp_drdata = 32'h1234_5678;

        // Contention: both sides re-request right after each done, memory answers at once
        run_random("contend", 60, 0, 1);
        // General randomized traffic
        run_random("rand", 1500, 3, 4);

        // Load whose request drops mid-transaction still completes
        dreq = 1'b1;
        dwe = 1'b0;
        dadr = 32'h88;
        tick();
        chk("drop_req", mem_req, 1'b1);
        dreq = 1'b0;
        tick();
        chk("drop_hold", mem_req, 1'b1);
        mem_done = 1'b1;
        mem_rdata = 32'hA5A5_0F0F;
        tick();
        chk("drop_ddone", ddone, 1'b1);
        chk("drop_drdata", drdata, 32'hA5A5_0F0F);
        mem_done = 1'b0;
        tick();

        // Timeout: memory never answers
        dreq = 1'b1;
        dwe = 1'b0;
        dadr = 32'h70;
        tick();
        hi = (mem_req === 1'b1) ? 1 : 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (mem_req !== 1'b1) break;
            hi++;
        end
        chk("tmo_busy_cycles", 32'(hi), 32'(TIMEOUT));
        chk("tmo_ddone", ddone, 1'b1);
        chk("tmo_drdata", drdata, 32'hDEAD_BEEF);
        chk("tmo_err", mem_err, 1'b1);
        dreq = 1'b0;
        tick();
        chk("tmo_ddone_once", ddone, 1'b0);
        tick();
        tick();
        chk("tmo_err_sticky", mem_err, 1'b1);

        // mem_done on the very edge that would abort wins
        ireq = 1'b1;
        iadr = 32'h44;
        tick();
        chk("edge_req", mem_req, 1'b1);
        repeat (TIMEOUT - 1) tick();
        chk("edge_still_busy", mem_req, 1'b1);
        mem_done = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("edge_idone", idone, 1'b1);
        chk("edge_irdata", irdata, 32'h0BAD_F00D);
        chk("edge_req_drop", mem_req, 1'b0);
        mem_done = 1'b0;
        ireq = 1'b0;
        tick();

        // Reset in the middle of a load
        dreq = 1'b1;
        dwe = 1'b0;
        dadr = 32'h90;
        tick();
        chk("rmid_req", mem_req, 1'b1);
        #1;
        reset = 1'b1;
        dreq = 1'b0;
        #1;
        chk("rmid_req_async", mem_req, 1'b0);
        chk("rmid_ddone_async", ddone, 1'b0);
        chk("rmid_err_async", mem_err, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("rmid_idle", mem_req, 1'b0);
        chk("rmid_no_ddone", ddone, 1'b0);
        chk("rmid_err_clear", mem_err, 1'b0);
        chk("rmid_drdata", drdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
